video_pattern_gen: RTL and testbench
====================================

// Module: video_pattern_gen
// PURPOSE
//  Source end of the scaler video stream (do/de/hs/vs, active-high). Generates
//  programmable raster timing plus a synthetic pixel pattern, driving scaler_h
//  and downstream stages in benches and in-system self-test. One pixel per clk.
// PARAMETERS
//  DATA_WIDTH  8   pixel width
//  CNT_WIDTH   12  width of timing counters/config fields
// PORTS
//  clk          in   1           pixel clock
//  rst          in   1           reset, asynchronous, active-high
//  en           in   1           run request
//  h_active     in   CNT_WIDTH   active pixels per line
//  h_fp/h_sync/h_bp in CNT_WIDTH front porch / hsync / back porch, pixels
//  v_active     in   CNT_WIDTH   active lines per frame
//  v_fp/v_sync/v_bp in CNT_WIDTH front porch / vsync / back porch, lines
//  pattern_sel  in   2           0 h-ramp, 1 v-ramp, 2 checker, 3 constant
//  pattern_const in  DATA_WIDTH  value for pattern 3
//  do_o         out  DATA_WIDTH  pixel data
//  de_o/hs_o/vs_o out 1          data enable / hsync / vsync
//  busy_o       out  1           frame in progress
//  cfg_err_o    out  1           1-cycle pulse: config rejected at frame start
//  frame_cnt_o  out  16          frames started (only with macro, see below)
// BEHAVIOUR
//  - Reset (async): all outputs 0, counters 0, stopped; shadow config cleared.
//    Reset mid-frame aborts immediately; restart begins at h=0,v=0.
//  - Line: h in [0,h_active) active, then fp, sync, bp; h_total = sum.
//    Frame: v same ordering on lines. hs_o=1 in h sync region on every line;
//    vs_o=1 for all clks of v sync lines; de_o=1 iff h and v both active.
//  - Outputs registered: 1 clk latency from counter state; do_o=0 when de_o=0.
//  - Start: stopped and en=1 -> next clk is h=0,v=0, busy_o=1. en sampled only
//    at frame end; en=0 mid-frame completes the frame, then stops, outputs 0.
//  - Config shadowed at each frame start only; mid-frame changes ignored.
//    Valid iff all fields >=1, h_sync>=5 (downstream hs qualifier needs >=5
//    clks), no total overflows CNT_WIDTH. Invalid: keep previous shadow, pulse
//    cfg_err_o; if none valid yet, stay stopped (busy_o=0).
//  - Wrap: h at h_total-1 -> 0 and v++; v at v_total-1 and h_total-1 -> frame end.
//  - Patterns: h-ramp do=h[DATA_WIDTH-1:0]; v-ramp do=v[DATA_WIDTH-1:0];
//    checker all-ones if h[3]^v[3] else 0; constant=pattern_const (shadowed).
// CONFIGURATION
//  VIDEO_PATTERN_GEN_FRAME_CNT_EN defined: frame_cnt_o present, +1 at each
//  frame start (wraps 16'hFFFF->0, reset 0); ramps add frame_cnt low bits
//  (moving ramp, mod 2^DATA_WIDTH). Undefined: port absent, static ramps.
// STRUCTURE
//  video_pkg: pattern_sel encodings (PAT_HRAMP..PAT_CONST), HS_MIN=5.
//  Sub-module video_timing_cnt: h/v counters, region decode, wrap, frame end;
//  top holds shadow config, run control, pattern mux, output registers.
// TESTING
//  Cfg 8/2/5/3 h, 4/1/2/1 v, en=1 -> 18-clk lines, 144-clk frames, 32 de/frame,
//   hs_o high 5 clks at h=10..14, vs_o high 36 clks (lines 5..6).
//  Pattern 0 -> do_o 0..7 each active line; pattern 2, h_active=32 -> 8x0,8xFF.
//  Change h_active 8->6 mid-frame -> current frame 8, next frame 6 per line.
//  h_sync=3 at start -> cfg_err_o one pulse, previous timing retained.
//  rst pulse at v=2,h=4 -> all outputs 0 same clk; en=1 restarts at h=0,v=0.
//  en=0 at v=1 -> frame completes (144 clks total), then busy_o=0, outputs 0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared encodings for the synthetic video source: pattern selects,
// minimum hsync width and the layout of the packed timing config vector.
package video_pkg;

  typedef enum logic [1:0] {
    PAT_HRAMP = 2'd0,
    PAT_VRAMP = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_CONST = 2'd3
  } pat_e;

  // downstream hs qualifier needs at least this many clks
  localparam int HS_MIN = 5;

  localparam int NCFG    = 8;
  localparam int CFG_HA  = 0;
  localparam int CFG_HFP = 1;
  localparam int CFG_HS  = 2;
  localparam int CFG_HBP = 3;
  localparam int CFG_VA  = 4;
  localparam int CFG_VFP = 5;
  localparam int CFG_VS  = 6;
  localparam int CFG_VBP = 7;

endpackage

// File: rtl/video_timing_cnt.sv
// Raster h/v counters with region decode and wrap/frame-end detection.
// Ports: clk, rst (async high), run, 8 timing fields (shadowed by the
// caller); h_o/v_o counters, active/sync region flags, frame_end_o.
module video_timing_cnt
  import video_pkg::*;
#(
  parameter int CNT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [CNT_WIDTH-1:0] h_active,
  input  logic [CNT_WIDTH-1:0] h_fp,
  input  logic [CNT_WIDTH-1:0] h_sync,
  input  logic [CNT_WIDTH-1:0] h_bp,
  input  logic [CNT_WIDTH-1:0] v_active,
  input  logic [CNT_WIDTH-1:0] v_fp,
  input  logic [CNT_WIDTH-1:0] v_sync,
  input  logic [CNT_WIDTH-1:0] v_bp,
  output logic [CNT_WIDTH-1:0] h_o,
  output logic [CNT_WIDTH-1:0] v_o,
  output logic                 h_act_o,
  output logic                 hs_reg_o,
  output logic                 v_act_o,
  output logic                 vs_reg_o,
  output logic                 frame_end_o
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] h_q, h_d, v_q, v_d;
  logic [CNT_WIDTH-1:0] hs_start, hs_end, h_last;
  logic [CNT_WIDTH-1:0] vs_start, vs_end, v_last;
  logic                 line_end;

  always_comb begin
    hs_start = h_active + h_fp;
    hs_end   = hs_start + h_sync;
    h_last   = hs_end + h_bp - ONE;
    vs_start = v_active + v_fp;
    vs_end   = vs_start + v_sync;
    v_last   = vs_end + v_bp - ONE;
  end

  assign line_end    = (h_q == h_last);
  assign frame_end_o = line_end && (v_q == v_last);
  assign h_act_o     = (h_q < h_active);
  assign hs_reg_o    = (h_q >= hs_start) && (h_q < hs_end);
  assign v_act_o     = (v_q < v_active);
  assign vs_reg_o    = (v_q >= vs_start) && (v_q < vs_end);
  assign h_o         = h_q;
  assign v_o         = v_q;

  // while stopped the counters sit at 0 so a start begins at h=0,v=0
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (run) begin
      if (line_end) begin
        h_d = '0;
        v_d = frame_end_o ? '0 : v_q + ONE;
      end else begin
        h_d = h_q + ONE;
        v_d = v_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Programmable raster timing + synthetic pixel pattern source (do/de/hs/vs).
// Ports: clk, rst (async high), en, h/v timing fields, pattern_sel,
// pattern_const; do_o, de_o, hs_o, vs_o, busy_o, cfg_err_o, and
// frame_cnt_o only when VIDEO_PATTERN_GEN_FRAME_CNT_EN is defined
// (that macro also makes the ramps move by the frame count).
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CNT_WIDTH-1:0]  h_active,
  input  logic [CNT_WIDTH-1:0]  h_fp,
  input  logic [CNT_WIDTH-1:0]  h_sync,
  input  logic [CNT_WIDTH-1:0]  h_bp,
  input  logic [CNT_WIDTH-1:0]  v_active,
  input  logic [CNT_WIDTH-1:0]  v_fp,
  input  logic [CNT_WIDTH-1:0]  v_sync,
  input  logic [CNT_WIDTH-1:0]  v_bp,
  input  logic [1:0]            pattern_sel,
  input  logic [DATA_WIDTH-1:0] pattern_const,
  output logic [DATA_WIDTH-1:0] do_o,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  busy_o,
`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
  output logic [15:0]           frame_cnt_o,
`endif
  output logic                  cfg_err_o
);

  localparam int SW = CNT_WIDTH + 2;
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  logic [NCFG-1:0][CNT_WIDTH-1:0] cfg_in, cfg_d, cfg_q;
  logic [1:0]            sel_d, sel_q;
  logic [DATA_WIDTH-1:0] const_d, const_q;
  logic                  shv_d, shv_q;
  logic                  run_d, run_q;
  logic                  err_d, err_q;
  logic                  de_d, de_q, hs_d, hs_q, vs_d, vs_q;
  logic [DATA_WIDTH-1:0] do_d, do_q, pix, ramp_off;
  logic [SW-1:0]         h_sum, v_sum;
  logic                  cfg_ok, try_start, load, frame_end;
  logic                  frame_start;
  cnt_t                  h, v;
  logic                  h_act, hs_reg, v_act, vs_reg, tc_end;

  assign cfg_in = {v_bp, v_sync, v_fp, v_active,
                   h_bp, h_sync, h_fp, h_active};

  video_timing_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .run         (run_q),
    .h_active    (cfg_q[CFG_HA]),
    .h_fp        (cfg_q[CFG_HFP]),
    .h_sync      (cfg_q[CFG_HS]),
    .h_bp        (cfg_q[CFG_HBP]),
    .v_active    (cfg_q[CFG_VA]),
    .v_fp        (cfg_q[CFG_VFP]),
    .v_sync      (cfg_q[CFG_VS]),
    .v_bp        (cfg_q[CFG_VBP]),
    .h_o         (h),
    .v_o         (v),
    .h_act_o     (h_act),
    .hs_reg_o    (hs_reg),
    .v_act_o     (v_act),
    .vs_reg_o    (vs_reg),
    .frame_end_o (tc_end)
  );

  // totals are summed two bits wider so overflow shows in the top bits
  always_comb begin
    cfg_ok = 1'b1;
    for (int i = 0; i < NCFG; i++)
      if (cfg_in[i] == '0) cfg_ok = 1'b0;
    if (cfg_in[CFG_HS] < cnt_t'(HS_MIN)) cfg_ok = 1'b0;
    h_sum = SW'(cfg_in[CFG_HA]) + SW'(cfg_in[CFG_HFP])
          + SW'(cfg_in[CFG_HS]) + SW'(cfg_in[CFG_HBP]);
    v_sum = SW'(cfg_in[CFG_VA]) + SW'(cfg_in[CFG_VFP])
          + SW'(cfg_in[CFG_VS]) + SW'(cfg_in[CFG_VBP]);
    if (h_sum[SW-1:CNT_WIDTH] != '0) cfg_ok = 1'b0;
    if (v_sum[SW-1:CNT_WIDTH] != '0) cfg_ok = 1'b0;
  end

  // en and config only matter when stopped or on the last pixel
  always_comb begin
    frame_end = run_q && tc_end;
    try_start = en && (!run_q || frame_end);
    load      = try_start && cfg_ok;
    err_d     = try_start && !cfg_ok;
    cfg_d     = load ? cfg_in : cfg_q;
    sel_d     = load ? pattern_sel : sel_q;
    const_d   = load ? pattern_const : const_q;
    shv_d     = shv_q || load;
    if (run_q) run_d = frame_end ? en : 1'b1;
    else       run_d = try_start && (cfg_ok || shv_q);
    frame_start = run_d && (!run_q || frame_end);
  end

`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
  logic [15:0] frame_cnt_d, frame_cnt_q;
  always_comb begin
    frame_cnt_d = frame_start ? frame_cnt_q + 16'd1 : frame_cnt_q;
    ramp_off    = DATA_WIDTH'(frame_cnt_q);
  end
  assign frame_cnt_o = frame_cnt_q;
`else
  logic unused_fs;
  assign unused_fs = frame_start;
  assign ramp_off  = '0;
`endif

  always_comb begin
    pix = '0;
    unique case (pat_e'(sel_q))
      PAT_HRAMP: pix = DATA_WIDTH'(h) + ramp_off;
      PAT_VRAMP: pix = DATA_WIDTH'(v) + ramp_off;
      PAT_CHECK: pix = (h[3] ^ v[3]) ? '1 : '0;
      PAT_CONST: pix = const_q;
      default:   pix = '0;
    endcase
    de_d = run_q && h_act && v_act;
    hs_d = run_q && hs_reg;
    vs_d = run_q && vs_reg;
    do_d = de_d ? pix : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q   <= '0;
      sel_q   <= '0;
      const_q <= '0;
      shv_q   <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      do_q    <= '0;
`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      cfg_q   <= cfg_d;
      sel_q   <= sel_d;
      const_q <= const_d;
      shv_q   <= shv_d;
      run_q   <= run_d;
      err_q   <= err_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      do_q    <= do_d;
`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign do_o      = do_q;
  assign de_o      = de_q;
  assign hs_o      = hs_q;
  assign vs_o      = vs_q;
  assign busy_o    = run_q;
  assign cfg_err_o = err_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: raster reference model feeding a
// scoreboard queue, plus directed timing/pattern/reset scenarios.
module tb_video_pattern_gen;

  localparam int DW = 8;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [CW-1:0] h_active, h_fp, h_sync, h_bp;
  logic [CW-1:0] v_active, v_fp, v_sync, v_bp;
  logic [1:0]    pattern_sel;
  logic [DW-1:0] pattern_const;
  logic [DW-1:0] do_o;
  logic          de_o, hs_o, vs_o, busy_o, cfg_err_o;
`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
  logic [15:0]   frame_cnt_o;
`endif

  video_pattern_gen #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .h_active      (h_active),
    .h_fp          (h_fp),
    .h_sync        (h_sync),
    .h_bp          (h_bp),
    .v_active      (v_active),
    .v_fp          (v_fp),
    .v_sync        (v_sync),
    .v_bp          (v_bp),
    .pattern_sel   (pattern_sel),
    .pattern_const (pattern_const),
    .do_o          (do_o),
    .de_o          (de_o),
    .hs_o          (hs_o),
    .vs_o          (vs_o),
    .busy_o        (busy_o),
`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
    .frame_cnt_o   (frame_cnt_o),
`endif
    .cfg_err_o     (cfg_err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, sel, cst;
  } cfg_t;

  typedef struct {
    int dout;
    bit de, hs, vs, busy, err;
  } exp_t;

  exp_t sb[$];

  bit   m_run, m_have;
  int   m_pos;
  cfg_t m_sh;

  function automatic cfg_t cur_cfg();
    cfg_t c;
    c.ha = int'(h_active); c.hfp = int'(h_fp);
    c.hs = int'(h_sync);   c.hbp = int'(h_bp);
    c.va = int'(v_active); c.vfp = int'(v_fp);
    c.vs = int'(v_sync);   c.vbp = int'(v_bp);
    c.sel = int'(pattern_sel);
    c.cst = int'(pattern_const);
    return c;
  endfunction

  function automatic bit cfg_valid(cfg_t c);
    if (c.ha < 1 || c.hfp < 1 || c.hs < 5 || c.hbp < 1) return 0;
    if (c.va < 1 || c.vfp < 1 || c.vs < 1 || c.vbp < 1) return 0;
    if (c.ha + c.hfp + c.hs + c.hbp > 4095) return 0;
    if (c.va + c.vfp + c.vs + c.vbp > 4095) return 0;
    return 1;
  endfunction

  // reference model: position within the frame as a single pixel index
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run  = 0;
      m_have = 0;
      m_pos  = 0;
      m_sh   = '{default: 0};
      sb.delete();
    end else begin
      exp_t  e;
      cfg_t  c;
      int    ht, vt, h, v;
      bit    at_end, try_s, ok;
      e = '{default: 0};
      c = cur_cfg();
      ok = cfg_valid(c);
      at_end = 0;
      if (m_run) begin
        ht = m_sh.ha + m_sh.hfp + m_sh.hs + m_sh.hbp;
        vt = m_sh.va + m_sh.vfp + m_sh.vs + m_sh.vbp;
        h = m_pos % ht;
        v = m_pos / ht;
        at_end = (m_pos == ht * vt - 1);
        e.de = (h < m_sh.ha) && (v < m_sh.va);
        e.hs = (h >= m_sh.ha + m_sh.hfp) &&
               (h < m_sh.ha + m_sh.hfp + m_sh.hs);
        e.vs = (v >= m_sh.va + m_sh.vfp) &&
               (v < m_sh.va + m_sh.vfp + m_sh.vs);
        if (e.de) begin
          case (m_sh.sel)
            0: e.dout = h % 256;
            1: e.dout = v % 256;
            2: e.dout = (((h / 8) % 2) != ((v / 8) % 2)) ? 255 : 0;
            default: e.dout = m_sh.cst;
          endcase
        end
      end
      try_s = en && (!m_run || at_end);
      e.err = try_s && !ok;
      if (!m_run) begin
        m_run = try_s && (ok || m_have);
        m_pos = 0;
      end else if (at_end) begin
        m_run = en;
        m_pos = 0;
      end else begin
        m_pos = m_pos + 1;
      end
      if (try_s && ok) begin
        m_sh   = c;
        m_have = 1;
      end
      e.busy = m_run;
      sb.push_back(e);
    end
  end

  // monitor: one expected entry per clock while out of reset
  always @(negedge clk) begin
    if (rst) begin
      n_tests++;
      if (do_o != 0 || de_o || hs_o || vs_o || busy_o || cfg_err_o) begin
        n_fail++;
        $display("FAIL rst_hold got do=%0d de=%0b hs=%0b vs=%0b busy=%0b err=%0b, want all 0",
                 do_o, de_o, hs_o, vs_o, busy_o, cfg_err_o);
      end
    end else if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_empty at %0t got no expected entry", $time);
    end else begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (int'(do_o) != e.dout || de_o != e.de || hs_o != e.hs ||
          vs_o != e.vs || busy_o != e.busy || cfg_err_o != e.err) begin
        n_fail++;
        $display("FAIL sb t=%0t got do=%0d de=%0b hs=%0b vs=%0b busy=%0b err=%0b want do=%0d de=%0b hs=%0b vs=%0b busy=%0b err=%0b",
                 $time, do_o, de_o, hs_o, vs_o, busy_o, cfg_err_o,
                 e.dout, e.de, e.hs, e.vs, e.busy, e.err);
      end
    end
  end

  task automatic chk(string name, int got, int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_cfg(int ha, int hfp, int hs, int hbp,
                         int va, int vfp, int vs, int vbp,
                         int sel, int cst);
    h_active = CW'(ha); h_fp = CW'(hfp); h_sync = CW'(hs); h_bp = CW'(hbp);
    v_active = CW'(va); v_fp = CW'(vfp); v_sync = CW'(vs); v_bp = CW'(vbp);
    pattern_sel = 2'(sel);
    pattern_const = DW'(cst);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 3000) begin
      step();
      n++;
    end
    chk("idle_timeout", int'(busy_o), 0);
    step();
  endtask

  initial begin
    int nb, nde, nhs, nvs, k;
    set_cfg(8, 2, 5, 3, 4, 1, 2, 1, 0, 0);
    repeat (3) step();
    chk("reset_do", int'(do_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    rst = 1'b0;
    step();

    // invalid config with no valid shadow: pulse error, stay stopped
    h_sync = CW'(3);
    en = 1'b1;
    step();
    chk("err_first", int'(cfg_err_o), 1);
    chk("stopped_no_cfg", int'(busy_o), 0);
    en = 1'b0;
    h_sync = CW'(5);
    step();
    chk("err_first_clear", int'(cfg_err_o), 0);

    // reference timing, stop requested on line 1
    en = 1'b1;
    nb = 0; nde = 0; nhs = 0; nvs = 0; k = 0;
    for (int i = 0; i < 160; i++) begin
      if (i == 20) en = 1'b0;
      nb  += int'(busy_o);
      nhs += int'(hs_o);
      nvs += int'(vs_o);
      if (de_o) begin
        chk("hramp", int'(do_o), k % 8);
        k++;
        nde++;
      end
      step();
    end
    chk("busy_len", nb, 144);
    chk("de_count", nde, 32);
    chk("hs_count", nhs, 40);
    chk("vs_count", nvs, 36);
    chk("stop_de", int'(de_o), 0);

    // checkerboard across a 32-wide line
    set_cfg(32, 2, 5, 3, 4, 1, 2, 1, 2, 0);
    en = 1'b1;
    step();
    en = 1'b0;
    k = 0;
    for (int i = 0; i < 60 && k < 32; i++) begin
      if (de_o) begin
        chk("checker", int'(do_o), ((k / 8) % 2 == 1) ? 255 : 0);
        k++;
      end
      step();
    end
    chk("checker_len", k, 32);
    wait_idle();

    // mid-frame change of h_active is deferred to the next frame
    set_cfg(8, 2, 5, 3, 4, 1, 2, 1, 0, 0);
    en = 1'b1;
    step();
    h_active = CW'(6);
    nde = 0;
    for (int i = 0; i < 145; i++) begin
      nde += int'(de_o);
      step();
    end
    chk("frame1_de", nde, 32);
    en = 1'b0;
    nde = 0;
    for (int i = 0; i < 140; i++) begin
      nde += int'(de_o);
      step();
    end
    chk("frame2_de", nde, 24);
    wait_idle();

    // rejected start keeps the previous (h_active=6) timing
    h_active = CW'(8);
    h_sync = CW'(3);
    en = 1'b1;
    step();
    chk("err_pulse", int'(cfg_err_o), 1);
    chk("err_run", int'(busy_o), 1);
    en = 1'b0;
    step();
    chk("err_once", int'(cfg_err_o), 0);
    nde = 0;
    for (int i = 0; i < 130; i++) begin
      nde += int'(de_o);
      step();
    end
    chk("kept_de", nde, 24);
    wait_idle();

    // asynchronous reset at v=2,h=4 then restart
    set_cfg(8, 2, 5, 3, 4, 1, 2, 1, 0, 0);
    en = 1'b1;
    step();
    repeat (40) step();
    chk("pre_rst_de", int'(de_o), 1);
    rst = 1'b1;
    #1;
    chk("rst_async_de", int'(de_o), 0);
    chk("rst_async_do", int'(do_o), 0);
    chk("rst_async_busy", int'(busy_o), 0);
    step();
    rst = 1'b0;
    step();
    chk("restart_busy", int'(busy_o), 1);
    step();
    chk("restart_de", int'(de_o), 1);
    chk("restart_do0", int'(do_o), 0);
    step();
    chk("restart_do1", int'(do_o), 1);
    en = 1'b0;
    wait_idle();

    // randomized configs, mid-frame changes and en toggling
    for (int ep = 0; ep < 12; ep++) begin
      set_cfg($urandom_range(1, 10), $urandom_range(1, 3),
              $urandom_range(4, 7), $urandom_range(1, 3),
              $urandom_range(1, 4), $urandom_range(1, 2),
              $urandom_range(1, 2), $urandom_range(1, 2),
              $urandom_range(0, 3), $urandom_range(0, 255));
      en = 1'b1;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 49) == 0)
          set_cfg($urandom_range(0, 10), $urandom_range(1, 3),
                  $urandom_range(3, 8), $urandom_range(1, 3),
                  $urandom_range(1, 4), $urandom_range(0, 2),
                  $urandom_range(1, 2), $urandom_range(1, 2),
                  $urandom_range(0, 3), $urandom_range(0, 255));
        if ($urandom_range(0, 199) == 0) h_bp = CW'(4095);
        if ($urandom_range(0, 59) == 0) en = ($urandom_range(0, 3) != 0);
        step();
      end
    end
    en = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
